// File: rtl/imm_encoder.sv
// imm_encoder: two-stage pipelined encoder of 64-bit immediates into instruction fields,
// with a fit flag per format and a saturating count of non-fitting results.
module imm_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_imm64,
    input  logic [2:0]  in_ctrl,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [25:0] out_imm26,
    output logic        out_fits,
    output logic [2:0]  out_ctrl,
    output logic [15:0] err_count
);
    logic        s1_valid;
    logic [63:0] s1_imm;
    logic [2:0]  s1_ctrl;
    logic [25:0] enc_imm;
    logic        enc_fits;
    logic        adv;
    logic        fit_i;
    logic        fit_d;
    logic        fit_b;
    logic        fit_cb;
    logic        fit_lw;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    // signed formats fit when every bit from the field's sign bit upward matches
    assign fit_i  = ~|s1_imm[63:12];
    assign fit_d  = (&s1_imm[63:8])  | ~(|s1_imm[63:8]);
    assign fit_b  = (&s1_imm[63:25]) | ~(|s1_imm[63:25]);
    assign fit_cb = (&s1_imm[63:18]) | ~(|s1_imm[63:18]);
    assign fit_lw = (&s1_imm[63:15]) | ~(|s1_imm[63:15]);
    always_comb begin
        enc_imm  = s1_ctrl == 3'd0 ? {4'b0, s1_imm[11:0], 10'b0} :
                   s1_ctrl == 3'd1 ? {5'b0, s1_imm[8:0], 12'b0}  :
                   s1_ctrl == 3'd2 ? s1_imm[25:0]                :
                   s1_ctrl == 3'd3 ? {2'b0, s1_imm[18:0], 5'b0}  :
                   s1_ctrl == 3'd4 ? {5'b0, s1_imm[15:0], 5'b0}  : 26'd0;
        enc_fits = s1_ctrl == 3'd0 ? fit_i  :
                   s1_ctrl == 3'd1 ? fit_d  :
                   s1_ctrl == 3'd2 ? fit_b  :
                   s1_ctrl == 3'd3 ? fit_cb :
                   s1_ctrl == 3'd4 ? fit_lw : 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_imm    <= 64'd0;
            s1_ctrl   <= 3'd0;
            out_valid <= 1'b0;
            out_imm26 <= 26'd0;
            out_fits  <= 1'b0;
            out_ctrl  <= 3'd0;
            err_count <= 16'd0;
        end else begin
            if (adv) begin
                s1_valid  <= in_valid;
                s1_imm    <= in_imm64;
                s1_ctrl   <= in_ctrl;
                out_valid <= s1_valid;
                out_imm26 <= enc_imm;
                out_fits  <= enc_fits;
                out_ctrl  <= s1_ctrl;
            end
            if (out_valid && out_ready && !out_fits && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed stimulus against a queue-based format model checked every cycle.
module tb_imm_encoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_imm64;
    logic [2:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] out_imm26;
    logic        out_fits;
    logic [2:0]  out_ctrl;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [25:0] imm;
        logic        fits;
        logic [2:0]  ctrl;
        int          age;
    } exp_t;

    exp_t q[$];
    int   m_err = 0;
    exp_t pin;

    imm_encoder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm64(in_imm64), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm26(out_imm26),
        .out_fits(out_fits), .out_ctrl(out_ctrl), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // field width/position per format; fit is a numeric range test on the value
    function automatic exp_t model(input logic [63:0] v, input logic [2:0] c);
        exp_t   e;
        int     w;
        int     sh;
        longint sv;
        longint lim;
        e = '{imm: 26'd0, fits: 1'b0, ctrl: c, age: 0};
        if (c > 3'd4) return e;
        w   = c == 3'd0 ? 12 : c == 3'd1 ? 9 : c == 3'd2 ? 26 : c == 3'd3 ? 19 : 16;
        sh  = c == 3'd0 ? 10 : c == 3'd1 ? 12 : c == 3'd2 ? 0 : 5;
        sv  = longint'(v);
        lim = longint'(1) <<< (w - 1);
        e.fits = c == 3'd0 ? (v < 64'd4096) : (sv >= -lim && sv < lim);
        e.imm  = 26'((v & ((64'd1 << w) - 64'd1)) << sh);
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_err = 0;
        end else begin
            if (out_valid && out_ready && q.size() > 0) begin
                if (!q[0].fits && m_err < 65535) m_err++;
                void'(q.pop_front());
            end
            if (!out_valid || out_ready)
                foreach (q[i]) q[i].age = q[i].age + 1;
            if (in_valid && in_ready) q.push_back(model(in_imm64, in_ctrl));
        end
    end

    always @(negedge clk) begin
        logic ev;
        ev = q.size() > 0 && q[0].age >= 1;
        check("in_ready", in_ready, !out_valid || out_ready);
        check("out_valid", out_valid, ev);
        check("err_count", err_count, m_err);
        if (ev && out_valid) begin
            check("out_imm26", out_imm26, q[0].imm);
            check("out_fits", out_fits, q[0].fits);
            check("out_ctrl", out_ctrl, q[0].ctrl);
        end
    end

    task automatic send(input logic [63:0] v, input logic [2:0] c);
        logic acc;
        int   n = 0;
        in_valid = 1'b1;
        in_imm64 = v;
        in_ctrl  = c;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            n++;
        end while (!acc && n < 50);
        #1 in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
        end
    endtask

    task automatic wait_out(input logic [2:0] c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_valid && out_ctrl == c) && n < 20);
        if (!(out_valid && out_ctrl == c)) begin
            checks++;
            errors++;
            $display("FAIL out_timeout: got no result expected ctrl %0d within 20 cycles", c);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_imm64 = 64'd0;
        in_ctrl = 3'd0;
        out_ready = 1'b1;

        pin = model(64'hABC, 3'd0);
        check("pin_i_imm", pin.imm, 26'h02AF000);
        check("pin_i_fits", pin.fits, 1'b1);
        pin = model(64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
        check("pin_d_neg", pin.imm, 26'h01FF000);
        pin = model(64'h100, 3'd1);
        check("pin_d_fits", pin.fits, 1'b0);
        pin = model(64'hFFFF_FFFF_FFFC_0000, 3'd3);
        check("pin_cb_imm", pin.imm, 26'h0800000);
        pin = model(64'h5, 3'd6);
        check("pin_bad_imm", pin.imm, 26'h0);

        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_err", err_count, 16'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        send(64'h0000_0000_0000_0ABC, 3'd0);
        wait_out(3'd0);
        check("i_imm", out_imm26, 26'h02AF000);
        check("i_fits", out_fits, 1'b1);

        send(64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
        wait_out(3'd1);
        check("d_neg_imm", out_imm26, 26'h01FF000);
        check("d_neg_fits", out_fits, 1'b1);

        send(64'h100, 3'd1);
        wait_out(3'd1);
        check("d_big_imm", out_imm26, 26'h0100000);
        check("d_big_fits", out_fits, 1'b0);
        @(negedge clk);
        check("d_big_err", err_count, 16'd1);

        send(64'h4_0000, 3'd3);
        wait_out(3'd3);
        check("cb_big_fits", out_fits, 1'b0);
        send(64'hFFFF_FFFF_FFFC_0000, 3'd3);
        wait_out(3'd3);
        check("cb_neg_imm", out_imm26, 26'h0800000);
        check("cb_neg_fits", out_fits, 1'b1);

        send(64'h1, 3'd2);
        send(64'h7FFF, 3'd4);
        in_valid = 1'b1;
        in_imm64 = 64'h5;
        in_ctrl = 3'd6;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_imm", out_imm26, 26'h1);
            check("stall_ctrl", out_ctrl, 3'd2);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out(3'd4);
        check("lw_imm", out_imm26, 26'h00FFFE0);
        check("lw_fits", out_fits, 1'b1);
        wait_out(3'd6);
        check("bad_imm", out_imm26, 26'h0);
        check("bad_fits", out_fits, 1'b0);

        send(64'h100, 3'd1);
        send(64'h4_0000, 3'd3);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_err", err_count, 16'h0);
        repeat (4) begin
            @(negedge clk);
            check("no_stale", out_valid, 1'b0);
        end

        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_imm64 = 64'h100;
        in_ctrl = 3'd1;
        repeat (65534) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("sat_fffe", err_count, 16'hFFFE);
        send(64'h100, 3'd1);
        repeat (3) @(negedge clk);
        check("sat_ffff", err_count, 16'hFFFF);
        send(64'h100, 3'd1);
        repeat (3) @(negedge clk);
        check("sat_hold", err_count, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
